tt_sel_seq: RTL
===============

Name: tt_sel_seq

Overview:
- On-chip sequencer that drives the controller's three select inputs (ctrl_sel_rst_n, ctrl_sel_inc, ctrl_ena) to select one user design by address.
- Replaces external bit-banging of the control-high pads: a requester hands over a target address, and the block generates the reset/increment pulse train with programmable pulse timing, then (optionally) enables the design.
- Sits between a host-side request source (e.g. a config shift register or management interface) and the tt_ctrl select inputs.

Parameters:
- ADDR_W, 10, width of design address (selects any of 2^ADDR_W slots).
- HP_W, 4, width of the half-period timing field.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset. One clock; reset is synchronous and active-low.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request; high only in IDLE.
- req_addr  in  ADDR_W  target design address; sampled on accept.
- req_ena  in  1  assert ctrl_ena after selection; sampled on accept.
- half_period  in  HP_W  phase length minus one, in clk cycles; sampled on accept.
- ctrl_sel_rst_n  out  1  to controller, active-low select-counter reset.
- ctrl_sel_inc  out  1  to controller, select-counter increment strobe.
- ctrl_ena  out  1  to controller, enable for the selected design.
- busy  out  1  sequence in progress, i.e. not IDLE.
- done  out  1  one-cycle pulse when a sequence completes.
- cur_addr  out  ADDR_W  address the controller currently holds; valid when cur_valid=1.
- cur_valid  out  1  cur_addr is known.

Behaviour:
- Reset values (all outputs registered):
  - ctrl_sel_rst_n=1, ctrl_sel_inc=0, ctrl_ena=0.
  - busy=0, done=0, req_ready=1, cur_addr=0, cur_valid=0.
  - FSM returns to IDLE.
- Reset mid-sequence aborts immediately; the next rising edge with rst_n=0 forces the reset values above.
- Accept: req_valid && req_ready at edge T latches addr, ena, and H=half_period. req_ready drops at T+1.
- Phase length: every phase lasts exactly H+1 cycles, timed by a down-counter reloaded on each phase entry.
- States and outputs (outputs are valid during the state):
  - IDLE: outputs hold their values; req_ready=1.
  - DIS: ctrl_ena=0, cur_valid=0.
  - RST_LO: ctrl_sel_rst_n=0.
  - RST_HI: ctrl_sel_rst_n=1. cur_addr=0 and cur_valid=1 on exit.
  - INC_HI: ctrl_sel_inc=1.
  - INC_LO: ctrl_sel_inc=0. cur_addr increments by 1 on exit.
  - FIN: single cycle. done=1; ctrl_ena=latched ena from the following cycle onward (registered at the FIN edge).
- Transitions:
  - IDLE goes to DIS on accept.
  - DIS goes to RST_LO, then RST_LO goes to RST_HI.
  - RST_HI and INC_LO go to INC_HI if cur_addr != target, otherwise to FIN.
  - INC_HI goes to INC_LO.
  - FIN goes to IDLE.
- Address 0: no INC pulses (RST_HI goes straight to FIN).
- Max address (2^ADDR_W-1): all pulses are issued. The comparator uses the full width, with no wrap.
- Total sequence, accept to done: (H+1)*(3+2*addr) cycles in states DIS through INC_LO, plus 1 FIN cycle.
- req_valid outside IDLE is ignored; there is no queueing and no pre-emption.
- The sequence is never interrupted by a new request; done and the next accept cannot coincide because req_ready=0 in FIN.

Optional Feature:
- Macro TT_SEL_SEQ_INCR_EN.
- Defined:
  - On accept, if cur_valid=1 and req_addr >= cur_addr, the FSM skips RST_LO/RST_HI: DIS goes directly to INC_HI, or to FIN if the addresses are equal.
  - It issues req_addr-cur_addr pulses.
  - cur_valid stays 1 through DIS in this case.
  - If req_addr < cur_addr, or cur_valid=0, the full reset path is taken.
- Undefined: the full reset path is always taken, and cur_valid/cur_addr serve as status only.

Test Plan:
- Reset, then req addr=3, ena=1, H=1 accepted at T.
  - Expected pulse train: sel_rst_n low cycles T+3..T+4; 3 sel_inc pulses, each 2 cycles high and 2 cycles low.
  - done at T+19, then ctrl_ena=1, cur_addr=3, cur_valid=1.
- Req addr=0, H=0 → 1-cycle DIS, 1-cycle RST_LO, 1-cycle RST_HI, no inc pulses; done at T+4; cur_addr=0.
- Req addr=1023 (ADDR_W=10), H=0 → exactly 1023 inc pulses; cur_addr=1023; done at T+2050.
- req_valid held high during busy with a different addr → ignored; req_ready=0 until IDLE; second request accepted on the cycle after done.
- rst_n low during INC_HI at pulse 2 of addr=5 → next cycle: sel_inc=0, ctrl_ena=0, cur_valid=0, IDLE, req_ready=1.
- TT_SEL_SEQ_INCR_EN: select 3, then request 5.
  - Expected: no sel_rst_n low, 2 inc pulses, cur_addr=5.
  - A following request for 2 must take the full reset path with 2 pulses.
  - Without the macro, the 3→5 request issues a full reset and 5 pulses.

Source files
------------

// File: rtl/tt_sel_seq.sv
// ============================================================================
// tt_sel_seq
// ----------------------------------------------------------------------------
// Purpose:
//   On-chip sequencer for the controller's design-select inputs. A requester
//   hands over a target design address. The block then drives a
//   reset/increment pulse train on ctrl_sel_rst_n / ctrl_sel_inc so that the
//   controller's select counter ends up holding that address. It can then
//   optionally raise ctrl_ena for the selected design. Every phase of the
//   pulse train lasts half_period+1 clock cycles.
//
// Parameters:
//   ADDR_W         width of the design address (2^ADDR_W selectable slots)
//   HP_W           width of the half-period timing field
//
// Ports:
//   clk            system clock
//   rst_n          synchronous, active-low reset
//   req_valid      request present
//   req_ready      request can be accepted (high only while idle)
//   req_addr       target design address, sampled on accept
//   req_ena        raise ctrl_ena after selection, sampled on accept
//   half_period    phase length minus one in clk cycles, sampled on accept
//   ctrl_sel_rst_n active-low select-counter reset to the controller
//   ctrl_sel_inc   select-counter increment strobe to the controller
//   ctrl_ena       enable for the selected design
//   busy           a sequence is in progress
//   done           one-cycle pulse when a sequence completes
//   cur_addr       address the controller currently holds
//   cur_valid      cur_addr is known
//
// Configuration macro:
//   TT_SEL_SEQ_INCR_EN  when defined, a request whose address is at or above
//                       a known current address skips the select-counter
//                       reset. Only the missing increments are issued.
//                       When undefined, every request resets the counter first.
// ============================================================================
module tt_sel_seq #(
  parameter int ADDR_W = 10,
  parameter int HP_W   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_ena,
  input  logic [HP_W-1:0]   half_period,
  output logic              ctrl_sel_rst_n,
  output logic              ctrl_sel_inc,
  output logic              ctrl_ena,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] cur_addr,
  output logic              cur_valid
);

  // Sequencer states. The pulse train walks DIS -> RST_LO -> RST_HI and then
  // alternates INC_HI/INC_LO once per increment before the single FIN cycle.
  typedef enum logic [2:0] {
    S_IDLE,
    S_DIS,
    S_RST_LO,
    S_RST_HI,
    S_INC_HI,
    S_INC_LO,
    S_FIN
  } state_t;

  state_t r_state;
  state_t w_stateNext;

  // Request fields captured at accept time
  logic [ADDR_W-1:0] r_target;
  logic              r_ena;
  logic [HP_W-1:0]   r_hp;
  logic              r_incr;

  // Phase timer
  logic [HP_W-1:0]   r_cnt;

  // Registered outputs
  logic              r_ready;
  logic              r_selRstN;
  logic              r_selInc;
  logic              r_ctrlEna;
  logic              r_busy;
  logic              r_done;
  logic [ADDR_W-1:0] r_curAddr;
  logic              r_curValid;

  // Combinational helpers
  logic              w_accept;
  logic              w_phaseEnd;
  logic              w_phaseChange;
  logic [ADDR_W-1:0] w_addrInc;
  logic              w_incrOk;

  // A request is taken only while idle. r_ready is a registered copy of
  // "state is IDLE", so it is safe to use as the handshake qualifier.
  assign w_accept   = req_valid && r_ready;

  // The phase timer counts down from H to zero. The last cycle of a phase is
  // the one where the timer reads zero.
  assign w_phaseEnd = (r_cnt == '0);

  // The address the controller will hold once the current INC_LO phase ends.
  // The exit decision from INC_LO compares against this post-increment value,
  // so the pulse count comes out exactly equal to the target address.
  assign w_addrInc  = r_curAddr + ADDR_W'(1);

  // Any state change is a phase entry and reloads the timer.
  assign w_phaseChange = (w_stateNext != r_state);

`ifdef TT_SEL_SEQ_INCR_EN
  // Incremental selection is possible only when the counter's contents are
  // known. The counter can only count up, so the target must also not be
  // below the current address.
  assign w_incrOk = r_curValid && (req_addr >= r_curAddr);
`else
  // Without incremental selection every request takes the full reset path.
  assign w_incrOk = 1'b0;
`endif

  // State register. Reset drops straight back to IDLE from any state, which
  // also aborts a sequence that is in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next-state logic. Each timed state waits for its phase timer to reach
  // zero before it moves on. The decision to issue another increment uses the
  // address the counter holds after the current phase. That value is zero
  // when leaving RST_HI and the incremented value when leaving INC_LO.
  always_comb begin
    w_stateNext = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_stateNext = S_DIS;
        end
      end
      S_DIS: begin
        if (w_phaseEnd) begin
          if (r_incr) begin
            w_stateNext = (r_curAddr != r_target) ? S_INC_HI : S_FIN;
          end else begin
            w_stateNext = S_RST_LO;
          end
        end
      end
      S_RST_LO: begin
        if (w_phaseEnd) begin
          w_stateNext = S_RST_HI;
        end
      end
      S_RST_HI: begin
        if (w_phaseEnd) begin
          w_stateNext = (r_target != '0) ? S_INC_HI : S_FIN;
        end
      end
      S_INC_HI: begin
        if (w_phaseEnd) begin
          w_stateNext = S_INC_LO;
        end
      end
      S_INC_LO: begin
        if (w_phaseEnd) begin
          w_stateNext = (w_addrInc != r_target) ? S_INC_HI : S_FIN;
        end
      end
      S_FIN: begin
        w_stateNext = S_IDLE;
      end
      default: begin
        w_stateNext = S_IDLE;
      end
    endcase
  end

  // Request capture. Target address, enable request and half period are
  // frozen on accept. Later changes on the request inputs cannot disturb a
  // sequence that has already started. The incremental decision is also made
  // here, against the counter contents seen at accept time.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_target <= '0;
      r_ena    <= 1'b0;
      r_hp     <= '0;
      r_incr   <= 1'b0;
    end else if (w_accept) begin
      r_target <= req_addr;
      r_ena    <= req_ena;
      r_hp     <= half_period;
      r_incr   <= w_incrOk;
    end
  end

  // Phase timer. On accept it loads straight from the half_period input,
  // because r_hp is only being written on that same edge. On every later
  // phase entry it reloads from the captured copy. Otherwise it counts down
  // and parks at zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= half_period;
    end else if (w_phaseChange) begin
      r_cnt <= r_hp;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - HP_W'(1);
    end
  end

  // Handshake and status flags. They are registered from the next state, so
  // each flag is valid for exactly the cycles the FSM spends in the
  // matching state. done therefore lasts the single FIN cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_ready <= (w_stateNext == S_IDLE);
      r_busy  <= (w_stateNext != S_IDLE);
      r_done  <= (w_stateNext == S_FIN);
    end
  end

  // Select pins. The counter reset is driven low only in RST_LO. The
  // increment strobe is driven high only in INC_HI. In every other state,
  // including IDLE, both pins sit at their inactive levels.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_selRstN <= 1'b1;
      r_selInc  <= 1'b0;
    end else begin
      r_selRstN <= (w_stateNext != S_RST_LO);
      r_selInc  <= (w_stateNext == S_INC_HI);
    end
  end

  // Design enable. It is dropped for the whole sequence as soon as DIS is
  // entered. The new value is applied on the edge that leaves FIN, so the
  // design is only enabled once selection has fully completed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ctrlEna <= 1'b0;
    end else if (r_state == S_FIN) begin
      r_ctrlEna <= r_ena;
    end else if (w_stateNext == S_DIS) begin
      r_ctrlEna <= 1'b0;
    end
  end

  // Tracked controller address. Once the reset pulse has ended, the
  // controller is known to hold zero. Each completed increment pulse then
  // adds one. The address becomes unknown when a full-reset sequence starts.
  // An incremental sequence keeps it valid, because the counter is never
  // disturbed in that case.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_curAddr  <= '0;
      r_curValid <= 1'b0;
    end else begin
      if (w_accept && !w_incrOk) begin
        r_curValid <= 1'b0;
      end else if ((r_state == S_RST_HI) && w_phaseEnd) begin
        r_curValid <= 1'b1;
      end

      if ((r_state == S_RST_HI) && w_phaseEnd) begin
        r_curAddr <= '0;
      end else if ((r_state == S_INC_LO) && w_phaseEnd) begin
        r_curAddr <= w_addrInc;
      end
    end
  end

  assign req_ready      = r_ready;
  assign busy           = r_busy;
  assign done           = r_done;
  assign ctrl_sel_rst_n = r_selRstN;
  assign ctrl_sel_inc   = r_selInc;
  assign ctrl_ena       = r_ctrlEna;
  assign cur_addr       = r_curAddr;
  assign cur_valid      = r_curValid;

endmodule
